adder_seq: RTL and testbench
============================

Name: adder_seq

Overview:
- Parametrised multi-cycle add/subtract unit. Successor to the fixed 4-bit ripple adder.
- Operand width is WIDTH. The adder processes CHUNK bits per clock and carries between chunks in a register, so the ripple path stays short at any width.
- Adds a start/busy/done handshake, a subtract mode and a signed-overflow flag.
- Used wherever wide arithmetic may trade latency for area or timing.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle. Range 1..WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_in  input  1  request. Sampled only while busy_out=0.
- sub_in  input  1  0: A+B+c_in. 1: A-B-c_in (c_in acts as borrow-in).
- a_in  input  WIDTH  operand A. Captured at start.
- b_in  input  WIDTH  operand B. Captured at start.
- c_in  input  1  carry-in or borrow-in. Captured at start.
- busy_out  output  1  operation in progress.
- done_out  output  1  one-cycle pulse; results updated in this cycle.
- sum_out  output  WIDTH  result.
- c_out  output  1  raw carry out of the MSB. In subtract mode 1 means no borrow.
- ovf_out  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. busy_out, done_out, sum_out, c_out, ovf_out and all internal registers are 0.
- FSM has two states, IDLE and RUN.
- IDLE transition:
  - On an edge where start_in=1, capture a_in and b_in.
  - Store b_eff = sub_in ? ~b_in : b_in.
  - Store carry register = c_in ^ sub_in.
  - Clear the chunk counter to 0. Go to RUN; busy_out=1 from this edge.
- RUN, at each edge, for chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1):
  - Compute {carry, s} = a_k + b_eff_k + carry.
  - Write s into the internal result register.
  - Counter increments.
  - Implementation choice: an index pointer or right-shift registers. Either is acceptable if the externally visible behaviour below holds.
- Completion, at the edge that processes chunk NCHUNK-1:
  - sum_out <= full result. c_out <= final carry.
  - ovf_out <= carry into the MSB XOR carry out of the MSB, equivalently (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
  - done_out=1 for exactly one cycle. busy_out=0. Return to IDLE.
- Latency: start sampled at edge E0; done_out high and results valid after edge E_NCHUNK, i.e. NCHUNK cycles.
- With CHUNK=WIDTH: NCHUNK=1, and done follows the start edge by one cycle.
- sum_out, c_out and ovf_out hold their last value until the next completion. They do not change during RUN.
- start_in while busy_out=1 is ignored. It is not queued.
- a_in, b_in, sub_in and c_in may change freely after the start edge.
- Back-to-back: start_in=1 in the done_out cycle (busy_out=0) is accepted. Throughput is one operation per NCHUNK cycles.
- Wrap-around: the result is modulo 2^WIDTH. The carry out of the MSB is reported only on c_out.
- Reset mid-operation: aborts immediately. No done_out pulse; outputs are cleared to 0.
- Subtract identity: A-B-c_in = A + ~B + (1-c_in), so c_out=0 indicates a borrow.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Add, A=0x1234, B=0x4321, c_in=0 -> done_out exactly 4 cycles after the start edge, with sum_out=0x5555, c_out=0, ovf_out=0. busy_out is high for 4 cycles.
- Carry chain, A=0xFFFF, B=0x0001, c_in=0 -> sum_out=0x0000, c_out=1, ovf_out=0.
  - Same operands with c_in=1 -> sum_out=0x0001, c_out=1.
- Signed overflow, A=0x7FFF, B=0x0001 add -> sum_out=0x8000, c_out=0, ovf_out=1.
  - A=0x8000, B=0x0001, sub -> sum_out=0x7FFF, c_out=1, ovf_out=1.
- Subtract, A=0x0005, B=0x0007, sub=1, c_in=0 -> sum_out=0xFFFE, c_out=0, ovf_out=0.
  - Same with c_in=1 -> sum_out=0xFFFD.
- Handshake:
  - start_in pulsed again 2 cycles into RUN with different operands -> ignored; the first result is unchanged.
  - New start in the done cycle -> accepted; second done exactly 4 cycles later.
  - rst_n low for 1 cycle mid-RUN -> busy_out, sum_out, c_out and ovf_out read 0 immediately, and no done_out pulse follows.
- Parameter sweep, CHUNK ∈ {1, 4, 16}, WIDTH=16, 1000 random ops each -> results match the A±B±c_in reference model, and latency equals WIDTH/CHUNK.

Source files
------------

// File: rtl/adder_seq_if.sv
// ----------------------------------------------------------------------------
// adder_seq_if
// Request/response bundle for the multi-cycle add/subtract unit.
//
//   start_in  request strobe, only looked at while busy_out is low
//   sub_in    0: A+B+c_in, 1: A-B-c_in (c_in is then a borrow-in)
//   a_in      operand A, captured on the accepted start edge
//   b_in      operand B, captured on the accepted start edge
//   c_in      carry-in / borrow-in, captured on the accepted start edge
//   busy_out  operation in progress
//   done_out  one-cycle pulse, results updated in this cycle
//   sum_out   result, modulo 2^WIDTH
//   c_out     raw carry out of the MSB (subtract: 1 means no borrow)
//   ovf_out   two's-complement signed overflow
//
// master: requester side. slave: the arithmetic unit.
// ----------------------------------------------------------------------------
interface adder_seq_if #(
   parameter int WIDTH = 16
);
   logic             start_in;
   logic             sub_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic             busy_out;
   logic             done_out;
   logic [WIDTH-1:0] sum_out;
   logic             c_out;
   logic             ovf_out;

   modport master (
      output start_in, sub_in, a_in, b_in, c_in,
      input  busy_out, done_out, sum_out, c_out, ovf_out
   );

   modport slave (
      input  start_in, sub_in, a_in, b_in, c_in,
      output busy_out, done_out, sum_out, c_out, ovf_out
   );
endinterface

// File: rtl/adder_seq.sv
// ----------------------------------------------------------------------------
// adder_seq
// Multi-cycle add/subtract unit. Operands are WIDTH bits wide and are summed
// CHUNK bits per clock, with the inter-chunk carry held in a register so the
// combinational ripple path never exceeds CHUNK bits. One operation takes
// NCHUNK = WIDTH/CHUNK cycles from the accepted start edge to done_out.
// WIDTH must be a multiple of CHUNK, and 1 <= CHUNK <= WIDTH.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation
//   bus    adder_seq_if.slave (start/sub/operands in, busy/done/results out)
//
// Operands are held in right-shift registers: the chunk being processed is
// always the low CHUNK bits, and each new partial sum enters the result
// register from the top. After NCHUNK shifts the result is fully aligned.
// ----------------------------------------------------------------------------
module adder_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   adder_seq_if.slave  bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // state and datapath registers
   state_t             state_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_eff_r;
   logic               carry_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   res_r;
   logic [WIDTH-1:0]   sum_r;
   logic               c_out_r;
   logic               ovf_r;
   logic               done_r;
   logic               busy_r;

   // next-state values
   state_t             state_next_s;
   logic [WIDTH-1:0]   a_next_s;
   logic [WIDTH-1:0]   b_eff_next_s;
   logic               carry_next_s;
   logic [CNT_W-1:0]   cnt_next_s;
   logic [WIDTH-1:0]   res_next_s;
   logic [WIDTH-1:0]   sum_next_s;
   logic               c_out_next_s;
   logic               ovf_next_s;
   logic               done_next_s;
   logic               busy_next_s;

   // per-chunk arithmetic
   logic [CHUNK:0]     chunk_sum_s;
   logic [WIDTH-1:0]   res_step_s;
   logic               last_s;

   // Chunk adder on the low CHUNK bits; the partial sum is shifted in from
   // the top of the result register so chunk 0 ends up at bit 0.
   always_comb begin
      chunk_sum_s = {1'b0, a_r[CHUNK-1:0]}
                  + {1'b0, b_eff_r[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_r};
      res_step_s  = (res_r >> CHUNK)
                  | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << (WIDTH - CHUNK));
      last_s      = (cnt_r == LAST_IDX);
   end

   // Next-state and datapath update logic for the IDLE/RUN controller.
   always_comb begin
      state_next_s = state_r;
      a_next_s     = a_r;
      b_eff_next_s = b_eff_r;
      carry_next_s = carry_r;
      cnt_next_s   = cnt_r;
      res_next_s   = res_r;
      sum_next_s   = sum_r;
      c_out_next_s = c_out_r;
      ovf_next_s   = ovf_r;
      done_next_s  = 1'b0;

      case (state_r)
         IDLE: begin
            if (bus.start_in) begin
               // Subtract is A + ~B + ~borrow, so both B and the carry-in
               // are inverted at capture time and RUN only ever adds.
               a_next_s     = bus.a_in;
               b_eff_next_s = bus.sub_in ? ~bus.b_in : bus.b_in;
               carry_next_s = bus.c_in ^ bus.sub_in;
               cnt_next_s   = {CNT_W{1'b0}};
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end

         RUN: begin
            a_next_s     = a_r >> CHUNK;
            b_eff_next_s = b_eff_r >> CHUNK;
            carry_next_s = chunk_sum_s[CHUNK];
            res_next_s   = res_step_s;
            cnt_next_s   = cnt_r + CNT_W'(1);
            if (last_s) begin
               // On the final chunk the low bits of a_r/b_eff_r hold the
               // operand MSBs, and the top partial-sum bit is the result MSB.
               sum_next_s   = res_step_s;
               c_out_next_s = chunk_sum_s[CHUNK];
               ovf_next_s   = (a_r[CHUNK-1] == b_eff_r[CHUNK-1])
                           && (chunk_sum_s[CHUNK-1] != a_r[CHUNK-1]);
               done_next_s  = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = RUN;
            end
         end

         default: begin
            state_next_s = IDLE;
         end
      endcase

      busy_next_s = (state_next_s == RUN);
   end

   // State and datapath registers; reset clears everything and aborts RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_eff_r <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         res_r   <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         c_out_r <= 1'b0;
         ovf_r   <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         a_r     <= a_next_s;
         b_eff_r <= b_eff_next_s;
         carry_r <= carry_next_s;
         cnt_r   <= cnt_next_s;
         res_r   <= res_next_s;
         sum_r   <= sum_next_s;
         c_out_r <= c_out_next_s;
         ovf_r   <= ovf_next_s;
         done_r  <= done_next_s;
         busy_r  <= busy_next_s;
      end
   end

   assign bus.busy_out = busy_r;
   assign bus.done_out = done_r;
   assign bus.sum_out  = sum_r;
   assign bus.c_out    = c_out_r;
   assign bus.ovf_out  = ovf_r;

endmodule

// File: tb/tb_adder_seq.sv
// ----------------------------------------------------------------------------
// tb_adder_seq
// Directed table of add/subtract vectors on a WIDTH=16, CHUNK=4 instance,
// hand-written handshake sequences (ignored start, back-to-back, reset
// mid-operation), and a random sweep run side by side on CHUNK=1, 4 and 16
// instances against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_adder_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   adder_seq_if #(.WIDTH(16)) bus1  ();
   adder_seq_if #(.WIDTH(16)) bus4  ();
   adder_seq_if #(.WIDTH(16)) bus16 ();

   adder_seq #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
   adder_seq #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
   adder_seq #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   typedef struct {
      logic        sub;
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] sum;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t tv [10];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow,
   // unsigned comparison for carry/no-borrow. Returns {c_out, ovf, sum}.
   function automatic logic [17:0] model(input logic sub, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      int ua, ub, uc, sa, sb, u, s;
      logic co, ov;
      ua = int'(a); ub = int'(b); uc = c ? 1 : 0;
      sa = $signed(a); sb = $signed(b);
      if (!sub) begin
         u  = ua + ub + uc;
         s  = sa + sb + uc;
         co = (u >= 65536);
      end else begin
         u  = ua - ub - uc;
         s  = sa - sb - uc;
         co = (ua >= ub + uc);
      end
      ov = (s > 32767) || (s < -32768);
      return {co, ov, u[15:0]};
   endfunction

   // Present a request on bus4 and let the next rising edge take it; the
   // inputs are then scrambled to show they were captured.
   task automatic issue4(input logic s, input logic [15:0] a, input logic [15:0] b, input logic c);
      bus4.sub_in   = s;
      bus4.a_in     = a;
      bus4.b_in     = b;
      bus4.c_in     = c;
      bus4.start_in = 1'b1;
      @(posedge clk); #1;
      bus4.start_in = 1'b0;
      bus4.sub_in   = ~s;
      bus4.a_in     = ~a;
      bus4.b_in     = b ^ 16'h5A5A;
      bus4.c_in     = ~c;
   endtask

   // Count edges until done_out, and the cycles busy_out was seen high.
   task automatic wait_done4(output int lat, output int busy_n);
      lat    = 0;
      busy_n = (bus4.busy_out === 1'b1) ? 1 : 0;
      while (bus4.done_out !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (bus4.busy_out === 1'b1) busy_n++;
      end
   endtask

   task automatic drive_all(input logic st, input logic s, input logic [15:0] a,
                            input logic [15:0] b, input logic c);
      bus1.start_in  = st; bus1.sub_in  = s; bus1.a_in  = a; bus1.b_in  = b; bus1.c_in  = c;
      bus4.start_in  = st; bus4.sub_in  = s; bus4.a_in  = a; bus4.b_in  = b; bus4.c_in  = c;
      bus16.start_in = st; bus16.sub_in = s; bus16.a_in = a; bus16.b_in = b; bus16.c_in = c;
   endtask

   initial begin
      int lat, busy_n, dn;
      int l1, l4, l16;
      logic [17:0] exp, r1, r4, r16;
      logic        rs, rc;
      logic [15:0] ra, rb;

      tv[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      tv[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tv[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
      tv[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tv[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      tv[5] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tv[6] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFD, 1'b0, 1'b0};
      tv[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tv[8] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0001, 1'b1, 1'b0};
      tv[9] = '{1'b0, 16'hA5A5, 16'h0F0F, 1'b1, 16'hB4B5, 1'b0, 1'b0};

      drive_all(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {bus4.busy_out, bus4.done_out, bus4.c_out, bus4.ovf_out, bus4.sum_out}, 32'h0);
      rst_n = 1'b1;

      // directed table on the CHUNK=4 instance
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         issue4(tv[i].sub, tv[i].a, tv[i].b, tv[i].c);
         wait_done4(lat, busy_n);
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_busy_cycles", i), busy_n, 4);
         check($sformatf("vec%0d_result", i),
               {bus4.c_out, bus4.ovf_out, bus4.sum_out}, {tv[i].co, tv[i].ov, tv[i].sum});
      end

      // start during RUN is ignored and not queued
      @(negedge clk);
      issue4(1'b0, 16'h1234, 16'h4321, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      bus4.a_in = 16'hFFFF; bus4.b_in = 16'hFFFF; bus4.sub_in = 1'b1; bus4.start_in = 1'b1;
      @(posedge clk); #1;
      bus4.start_in = 1'b0;
      wait_done4(lat, busy_n);
      check("ignored_start_latency", lat, 1);
      check("ignored_start_result", {bus4.c_out, bus4.ovf_out, bus4.sum_out}, {1'b0, 1'b0, 16'h5555});
      dn = 0;
      repeat (8) begin @(posedge clk); #1; if (bus4.done_out === 1'b1) dn++; end
      check("ignored_start_not_queued", dn, 0);

      // back-to-back: new start in the done cycle
      @(negedge clk);
      issue4(1'b0, 16'hFFFF, 16'h0001, 1'b1);
      wait_done4(lat, busy_n);
      check("b2b_first_latency", lat, 4);
      check("b2b_first_result", {bus4.c_out, bus4.ovf_out, bus4.sum_out}, {1'b1, 1'b0, 16'h0001});
      issue4(1'b1, 16'h0005, 16'h0007, 1'b0);
      wait_done4(lat, busy_n);
      check("b2b_second_latency", lat, 4);
      check("b2b_second_result", {bus4.c_out, bus4.ovf_out, bus4.sum_out}, {1'b0, 1'b0, 16'hFFFE});
      @(posedge clk); #1;
      check("done_single_pulse", bus4.done_out, 1'b0);

      // reset two cycles into RUN
      @(negedge clk);
      issue4(1'b0, 16'h7FFF, 16'h0001, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrun_reset_clear", {bus4.busy_out, bus4.done_out, bus4.c_out, bus4.ovf_out, bus4.sum_out}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dn = 0;
      repeat (8) begin @(posedge clk); #1; if (bus4.done_out === 1'b1) dn++; end
      check("midrun_reset_no_done", dn, 0);
      check("midrun_reset_idle", {bus4.busy_out, bus4.sum_out}, 32'h0);

      // random sweep across CHUNK = 1, 4, 16 in parallel
      for (int n = 0; n < 1000; n++) begin
         rs = 1'($urandom);
         rc = 1'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         exp = model(rs, ra, rb, rc);
         drive_all(1'b1, rs, ra, rb, rc);
         @(posedge clk); #1;
         drive_all(1'b0, ~rs, ~ra, ~rb, ~rc);
         l1 = 0; l4 = 0; l16 = 0;
         for (int cyc = 1; cyc <= 17; cyc++) begin
            @(posedge clk); #1;
            if (bus1.done_out === 1'b1 && l1 == 0) l1 = cyc;
            if (bus4.done_out === 1'b1 && l4 == 0) l4 = cyc;
            if (bus16.done_out === 1'b1 && l16 == 0) l16 = cyc;
         end
         r1  = {bus1.c_out,  bus1.ovf_out,  bus1.sum_out};
         r4  = {bus4.c_out,  bus4.ovf_out,  bus4.sum_out};
         r16 = {bus16.c_out, bus16.ovf_out, bus16.sum_out};
         check($sformatf("sweep%0d_c1_latency", n), l1, 16);
         check($sformatf("sweep%0d_c4_latency", n), l4, 4);
         check($sformatf("sweep%0d_c16_latency", n), l16, 1);
         check($sformatf("sweep%0d_c1_result", n), r1, exp);
         check($sformatf("sweep%0d_c4_result", n), r4, exp);
         check($sformatf("sweep%0d_c16_result", n), r16, exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
